axis_data_fifo_pkt: RTL and testbench
=====================================

# axis_data_fifo_pkt

Parametrised AXI4-Stream data FIFO, the generalised successor of the plain data FIFO in the virtual FIFO datapath. It buffers beats (tdata/tkeep/tlast) in a configurable-depth memory and reports occupancy, almost-full and stored-packet count. Optionally it runs store-and-forward: a packet is presented downstream only once its tlast beat is stored. It sits between the stream ingress and the DDR write path of the virtual FIFO.

## Interface
- TDATA_BYTES, 8: data bytes per beat; tdata width is 8*TDATA_BYTES.
- TKEEP_WIDTH, TDATA_BYTES: tkeep width.
- DEPTH, 16: beats stored; power of two, >= 4.
- AF_THRESH, DEPTH-2: almost_full asserts when fill_level >= AF_THRESH; range 1..DEPTH.
- CNT_W, $clog2(DEPTH+1): width of fill_level and pkt_count (derived; do not override).

- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- target_tvalid / target_tready / target_tdata / target_tkeep / target_tlast  in/out/in/in/in  1/1/8*TDATA_BYTES/TKEEP_WIDTH/1  AXI4-Stream slave.
- initiator_tvalid / initiator_tready / initiator_tdata / initiator_tkeep / initiator_tlast  out/in/out/out/out  1/1/8*TDATA_BYTES/TKEEP_WIDTH/1  AXI4-Stream master.
- fill_level  out  CNT_W  beats currently stored, 0..DEPTH.
- almost_full  out  1  fill_level >= AF_THRESH.
- pkt_count  out  CNT_W  complete packets (tlast beats) stored, 0..DEPTH.

## Operation
- Storage: DEPTH-entry array of {tlast, tkeep, tdata}. Write and read pointers are log2(DEPTH)+1 bits. The extra MSB distinguishes full from empty. Pointers wrap naturally modulo 2*DEPTH.
- Write: on target_tvalid && target_tready, the beat is stored at wr_ptr and wr_ptr increments.
- target_tready = !full, where full means fill_level == DEPTH. A read in the same cycle does not unblock a write while full.
- Read: first-word-fall-through. initiator_tdata/tkeep/tlast are driven from the entry at rd_ptr. On initiator_tvalid && initiator_tready, rd_ptr increments.
- fill_level: +1 on write only, -1 on read only, unchanged on a simultaneous read and write.
- pkt_count:
  - +1 when a beat with tlast=1 is written.
  - -1 when a beat with tlast=1 is read.
  - Unchanged when both happen in the same cycle.
- Output valid:
  - Cut-through (macro absent): initiator_tvalid = !empty.
  - Store-and-forward (see Configuration): see the gate below.
- Output stability: once initiator_tvalid is high, the outputs hold until accepted. Valid never drops without a handshake.
- Reset (aresetn low, asynchronous): pointers, fill_level and pkt_count are cleared.
  - Reset values: initiator_tvalid=0, target_tready=0, almost_full=0, fill_level=0, pkt_count=0. initiator_tdata/tkeep/tlast are don't-care.
  - After deassertion, target_tready rises on the first aclk edge.
  - Reset mid-packet discards all stored beats, including partial packets. The memory array itself is not reset.

## Timing
- Write-to-read latency: a beat written at edge N shows initiator_tvalid=1 after edge N (visible in cycle N+1) when the FIFO was empty. This holds in cut-through mode, and in store-and-forward mode when the beat carries tlast.
- fill_level, pkt_count and almost_full are registered and update at the edge of the handshake.
- Throughput: 1 beat/cycle sustained in both directions while not full/empty.
- All status outputs and target_tready are registered. initiator_tvalid is derived from registered state only. There is no combinational path from initiator_tready to target_tready.

## Configuration
- Macro: AXIS_DATA_FIFO_PKT_STORE_FORWARD_EN.
- Defined (store-and-forward): initiator_tvalid = !empty && (pkt_count != 0 || full).
  - The full override forwards a packet longer than DEPTH in cut-through fashion, avoiding deadlock.
  - Once the first beat of such a packet is released, valid stays gated only by !empty until its tlast beat is read.
  - A one-bit `forcing` register is set on the override and cleared on the tlast read.
- Undefined: the macro removes the gate and the `forcing` logic; initiator_tvalid = !empty.

## Test plan
- Reset then single beat: write tdata=0x11, tkeep=0xFF, tlast=1 at cycle 5 -> initiator_tvalid=1 in cycle 6 with identical payload; fill_level 0->1->0; pkt_count 0->1->0.
- Fill to full, DEPTH=16, AF_THRESH=14, initiator_tready=0: write 16 beats with tlast=0 -> almost_full=1 after the 14th write, target_tready=0 after the 16th, fill_level=16. Then read one beat -> target_tready=1 on the next cycle.
- Simultaneous read/write at fill_level=8 for 100 cycles -> fill_level stays 8; data order is preserved across pointer wrap-around.
- Store-and-forward (macro defined): write 3 beats with tlast on beat 3 -> initiator_tvalid=0 until the tlast write edge, then 1; 3 beats out in order.
- Oversize packet (macro defined), DEPTH=16: a 20-beat packet -> when full=1, valid rises; all 20 beats are delivered in order; `forcing` clears after the tlast read.
- Reset mid-packet: assert aresetn=0 with fill_level=5 -> all outputs take their reset values immediately. After release, new data arrives with no stale beats.

Source files
------------

// File: rtl/axis_data_fifo_pkt.sv
// -----------------------------------------------------------------------------
// axis_data_fifo_pkt
//
// AXI4-Stream data FIFO with occupancy, almost-full and stored-packet
// reporting. Sits between the stream ingress and the DDR write path of the
// virtual FIFO. Beats ({tlast, tkeep, tdata}) are held in a DEPTH-entry
// array and presented first-word-fall-through on the initiator side.
//
// Optional feature (compile-time macro):
//   AXIS_DATA_FIFO_PKT_STORE_FORWARD_EN
//     Defined   : store-and-forward. A packet is offered downstream only once
//                 its tlast beat is stored. A packet longer than DEPTH is
//                 released cut-through when the FIFO fills, so it can never
//                 deadlock.
//     Undefined : cut-through. initiator_tvalid = !empty.
//
// Parameters:
//   TDATA_BYTES  data bytes per beat (tdata is 8*TDATA_BYTES bits)
//   TKEEP_WIDTH  tkeep width
//   DEPTH        beats stored; power of two, >= 4
//   AF_THRESH    almost_full asserts when fill_level >= AF_THRESH (1..DEPTH)
//   CNT_W        width of fill_level / pkt_count (derived, do not override)
//
// Ports:
//   aclk, aresetn              clock, asynchronous active-low reset
//   target_*                   AXI4-Stream slave (ingress)
//   initiator_*                AXI4-Stream master (egress)
//   fill_level                 beats currently stored, 0..DEPTH
//   almost_full                fill_level >= AF_THRESH
//   pkt_count                  complete packets (tlast beats) stored
// -----------------------------------------------------------------------------
module axis_data_fifo_pkt #(
  parameter int TDATA_BYTES = 8,
  parameter int TKEEP_WIDTH = TDATA_BYTES,
  parameter int DEPTH       = 16,
  parameter int AF_THRESH   = DEPTH - 2,
  parameter int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                     aclk,
  input  logic                     aresetn,

  input  logic                     target_tvalid,
  output logic                     target_tready,
  input  logic [8*TDATA_BYTES-1:0] target_tdata,
  input  logic [TKEEP_WIDTH-1:0]   target_tkeep,
  input  logic                     target_tlast,

  output logic                     initiator_tvalid,
  input  logic                     initiator_tready,
  output logic [8*TDATA_BYTES-1:0] initiator_tdata,
  output logic [TKEEP_WIDTH-1:0]   initiator_tkeep,
  output logic                     initiator_tlast,

  output logic [CNT_W-1:0]         fill_level,
  output logic                     almost_full,
  output logic [CNT_W-1:0]         pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = 8 * TDATA_BYTES;

  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef struct packed {
    logic                   last;
    logic [TKEEP_WIDTH-1:0] keep;
    logic [DW-1:0]          data;
  } beat_t;

  // ---------------------------------------------------------------------------
  // Storage and pointers. The pointers carry one extra MSB so that equal
  // low bits with differing MSBs means "full" and fully equal means "empty";
  // they wrap naturally modulo 2*DEPTH.
  // ---------------------------------------------------------------------------
  beat_t         mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  beat_t         head;

  logic          full;
  logic          empty;
  logic          wr_fire;
  logic          rd_fire;
  logic          wr_last;
  logic          rd_last;

  logic [CNT_W-1:0] fill_next;
  logic [CNT_W-1:0] pkt_next;

  assign full  = (fill_level == CNT_DEPTH);
  assign empty = (wr_ptr == rd_ptr);

  // First-word-fall-through: the entry at rd_ptr is always on the outputs.
  assign head            = mem[rd_ptr[AW-1:0]];
  assign initiator_tdata = head.data;
  assign initiator_tkeep = head.keep;
  assign initiator_tlast = head.last;

  // target_tready is a registered !full, so a read in a full cycle cannot
  // open the write path until the following cycle.
  assign wr_fire = target_tvalid && target_tready;
  assign rd_fire = initiator_tvalid && initiator_tready;
  assign wr_last = wr_fire && target_tlast;
  assign rd_last = rd_fire && head.last;

  // ---------------------------------------------------------------------------
  // Output valid
  // ---------------------------------------------------------------------------
`ifdef AXIS_DATA_FIFO_PKT_STORE_FORWARD_EN
  // Set when an oversize packet is released because the FIFO filled before
  // its tlast arrived; holds valid up (gated only by !empty) until that
  // packet's tlast beat leaves, so valid never drops without a handshake
  // once the first beat has gone out and full has cleared.
  logic forcing;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      forcing <= 1'b0;
    end else if (rd_last) begin
      forcing <= 1'b0;
    end else if (full && (pkt_count == '0)) begin
      forcing <= 1'b1;
    end
  end

  assign initiator_tvalid = !empty && ((pkt_count != '0) || full || forcing);
`else
  assign initiator_tvalid = !empty;
`endif

  // ---------------------------------------------------------------------------
  // Next-state occupancy and packet count. A simultaneous increment and
  // decrement cancel out.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    fill_next = fill_level;
    unique case ({wr_fire, rd_fire})
      2'b10:   fill_next = fill_level + CNT_ONE;
      2'b01:   fill_next = fill_level - CNT_ONE;
      default: fill_next = fill_level;
    endcase
  end

  always_comb begin
    pkt_next = pkt_count;
    unique case ({wr_last, rd_last})
      2'b10:   pkt_next = pkt_count + CNT_ONE;
      2'b01:   pkt_next = pkt_count - CNT_ONE;
      default: pkt_next = pkt_count;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered control state and status outputs
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill_level    <= '0;
      pkt_count     <= '0;
      almost_full   <= 1'b0;
      target_tready <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      fill_level    <= fill_next;
      pkt_count     <= pkt_next;
      almost_full   <= (fill_next >= CNT_AF);
      target_tready <= (fill_next != CNT_DEPTH);
    end
  end

  // ---------------------------------------------------------------------------
  // Beat storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; stale contents are unreachable because
  // reset empties the pointers, and leaving it unreset lets it map to RAM.
  always_ff @(posedge aclk) begin
    if (wr_fire) begin
      mem[wr_ptr[AW-1:0]] <= '{last: target_tlast,
                               keep: target_tkeep,
                               data: target_tdata};
    end
  end

endmodule

// File: tb/tb_axis_data_fifo_pkt.sv
// -----------------------------------------------------------------------------
// tb_axis_data_fifo_pkt
//
// Directed bench for axis_data_fifo_pkt (DEPTH=16, AF_THRESH=14, 8-byte
// beats). Inputs are driven and outputs observed 1 time unit after each
// rising edge. Store-and-forward steps are built only when
// AXIS_DATA_FIFO_PKT_STORE_FORWARD_EN is defined.
// -----------------------------------------------------------------------------
module tb_axis_data_fifo_pkt;

  localparam int TDATA_BYTES = 8;
  localparam int TKEEP_WIDTH = 8;
  localparam int DEPTH       = 16;
  localparam int AF_THRESH   = 14;
  localparam int CNT_W       = $clog2(DEPTH + 1);

  logic                   aclk;
  logic                   aresetn;
  logic                   target_tvalid;
  logic                   target_tready;
  logic [63:0]            target_tdata;
  logic [TKEEP_WIDTH-1:0] target_tkeep;
  logic                   target_tlast;
  logic                   initiator_tvalid;
  logic                   initiator_tready;
  logic [63:0]            initiator_tdata;
  logic [TKEEP_WIDTH-1:0] initiator_tkeep;
  logic                   initiator_tlast;
  logic [CNT_W-1:0]       fill_level;
  logic                   almost_full;
  logic [CNT_W-1:0]       pkt_count;

  int checks = 0;
  int errors = 0;

  axis_data_fifo_pkt #(
    .TDATA_BYTES (TDATA_BYTES),
    .TKEEP_WIDTH (TKEEP_WIDTH),
    .DEPTH       (DEPTH),
    .AF_THRESH   (AF_THRESH)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .target_tvalid    (target_tvalid),
    .target_tready    (target_tready),
    .target_tdata     (target_tdata),
    .target_tkeep     (target_tkeep),
    .target_tlast     (target_tlast),
    .initiator_tvalid (initiator_tvalid),
    .initiator_tready (initiator_tready),
    .initiator_tdata  (initiator_tdata),
    .initiator_tkeep  (initiator_tkeep),
    .initiator_tlast  (initiator_tlast),
    .fill_level       (fill_level),
    .almost_full      (almost_full),
    .pkt_count        (pkt_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [63:0] bd(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction

  initial begin
    int wr_idx;
    int rd_idx;
    int guard;

    aresetn          = 1'b0;
    target_tvalid    = 1'b0;
    target_tdata     = '0;
    target_tkeep     = '0;
    target_tlast     = 1'b0;
    initiator_tready = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) tick();
    check("rst_ivalid", 64'(initiator_tvalid), 64'd0);
    check("rst_tready", 64'(target_tready),    64'd0);
    check("rst_af",     64'(almost_full),      64'd0);
    check("rst_fill",   64'(fill_level),       64'd0);
    check("rst_pkt",    64'(pkt_count),        64'd0);
    aresetn = 1'b1;
    check("rel_tready_low", 64'(target_tready), 64'd0);
    tick();
    check("rel_tready_high", 64'(target_tready), 64'd1);

    // ---------------- single beat ----------------
    target_tvalid = 1'b1;
    target_tdata  = 64'h11;
    target_tkeep  = 8'hFF;
    target_tlast  = 1'b1;
    check("sb_ivalid_pre", 64'(initiator_tvalid), 64'd0);
    tick();
    target_tvalid = 1'b0;
    target_tlast  = 1'b0;
    check("sb_ivalid", 64'(initiator_tvalid), 64'd1);
    check("sb_data",   initiator_tdata,       64'h11);
    check("sb_keep",   64'(initiator_tkeep),  64'hFF);
    check("sb_last",   64'(initiator_tlast),  64'd1);
    check("sb_fill1",  64'(fill_level),       64'd1);
    check("sb_pkt1",   64'(pkt_count),        64'd1);
    initiator_tready = 1'b1;
    tick();
    initiator_tready = 1'b0;
    check("sb_ivalid_after", 64'(initiator_tvalid), 64'd0);
    check("sb_fill0",        64'(fill_level),       64'd0);
    check("sb_pkt0",         64'(pkt_count),        64'd0);

    // ---------------- fill to full ----------------
    for (int i = 0; i < DEPTH; i++) begin
      target_tvalid = 1'b1;
      target_tdata  = bd(i);
      target_tkeep  = 8'(i * 3);
      target_tlast  = 1'b0;
      check("fill_tready_before_write", 64'(target_tready), 64'd1);
      tick();
      if (i == AF_THRESH - 2) check("af_below_thresh", 64'(almost_full), 64'd0);
      if (i == AF_THRESH - 1) check("af_at_thresh",    64'(almost_full), 64'd1);
    end
    check("full_tready", 64'(target_tready), 64'd0);
    check("full_fill",   64'(fill_level),    64'd16);
    check("full_pkt",    64'(pkt_count),     64'd0);
    check("full_head",   initiator_tdata,    bd(0));
    check("full_keep",   64'(initiator_tkeep), 64'h00);

    // Read one beat while still offering a write: only the read happens.
    target_tvalid    = 1'b1;
    target_tdata     = 64'hDEAD;
    initiator_tready = 1'b1;
    tick();
    target_tvalid    = 1'b0;
    check("rd1_fill",   64'(fill_level),    64'd15);
    check("rd1_tready", 64'(target_tready), 64'd1);
    check("rd1_head",   initiator_tdata,    bd(1));
    check("rd1_keep",   64'(initiator_tkeep), 64'h03);

    // Drain to fill_level 8, checking order.
    rd_idx = 1;
    for (int i = 0; i < 7; i++) begin
      check("drain_to8_data", initiator_tdata, bd(rd_idx));
      tick();
      rd_idx++;
    end
    initiator_tready = 1'b0;
    check("at8_fill", 64'(fill_level), 64'd8);

    // ---------------- simultaneous read/write for 100 cycles ----------------
    wr_idx = DEPTH;
    for (int i = 0; i < 100; i++) begin
      target_tvalid    = 1'b1;
      target_tdata     = bd(wr_idx);
      target_tkeep     = 8'hFF;
      initiator_tready = 1'b1;
      check("rw_data", initiator_tdata, bd(rd_idx));
      tick();
      wr_idx++;
      rd_idx++;
    end
    target_tvalid    = 1'b0;
    initiator_tready = 1'b0;
    check("rw_fill", 64'(fill_level), 64'd8);

    initiator_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("rw_drain_data", initiator_tdata, bd(rd_idx));
      tick();
      rd_idx++;
    end
    initiator_tready = 1'b0;
    check("empty_ivalid", 64'(initiator_tvalid), 64'd0);
    check("empty_fill",   64'(fill_level),       64'd0);

    // ---------------- reset mid-packet ----------------
    for (int i = 0; i < 5; i++) begin
      target_tvalid = 1'b1;
      target_tdata  = 64'h5000 + 64'(i);
      target_tkeep  = 8'hFF;
      target_tlast  = (i == 1);
      tick();
    end
    target_tvalid = 1'b0;
    target_tlast  = 1'b0;
    check("mid_fill5", 64'(fill_level), 64'd5);
    check("mid_pkt1",  64'(pkt_count),  64'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("mid_rst_ivalid", 64'(initiator_tvalid), 64'd0);
    check("mid_rst_tready", 64'(target_tready),    64'd0);
    check("mid_rst_af",     64'(almost_full),      64'd0);
    check("mid_rst_fill",   64'(fill_level),       64'd0);
    check("mid_rst_pkt",    64'(pkt_count),        64'd0);
    #1;
    aresetn = 1'b1;
    tick();
    check("post_rst_tready", 64'(target_tready),    64'd1);
    check("post_rst_ivalid", 64'(initiator_tvalid), 64'd0);
    target_tvalid = 1'b1;
    target_tdata  = 64'hBEEF;
    target_tlast  = 1'b1;
    tick();
    target_tvalid = 1'b0;
    target_tlast  = 1'b0;
    check("post_rst_data",  initiator_tdata, 64'hBEEF);
    check("post_rst_fill",  64'(fill_level), 64'd1);
    check("post_rst_pkt",   64'(pkt_count),  64'd1);
    initiator_tready = 1'b1;
    tick();
    initiator_tready = 1'b0;
    check("post_rst_empty", 64'(initiator_tvalid), 64'd0);

`ifdef AXIS_DATA_FIFO_PKT_STORE_FORWARD_EN
    // ---------------- store-and-forward, 3-beat packet ----------------
    for (int i = 0; i < 3; i++) begin
      target_tvalid = 1'b1;
      target_tdata  = 64'h3000 + 64'(i);
      target_tlast  = (i == 2);
      tick();
      if (i < 2) check("sf_gate_closed", 64'(initiator_tvalid), 64'd0);
      else       check("sf_gate_open",   64'(initiator_tvalid), 64'd1);
    end
    target_tvalid    = 1'b0;
    target_tlast     = 1'b0;
    initiator_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("sf_out_valid", 64'(initiator_tvalid), 64'd1);
      check("sf_out_data",  initiator_tdata,       64'h3000 + 64'(i));
      tick();
    end
    initiator_tready = 1'b0;
    check("sf_empty", 64'(initiator_tvalid), 64'd0);

    // ---------------- oversize packet ----------------
    wr_idx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      target_tvalid = 1'b1;
      target_tdata  = bd(100 + wr_idx);
      target_tlast  = 1'b0;
      tick();
      wr_idx++;
      if (i == DEPTH - 2) check("ovr_gate_closed", 64'(initiator_tvalid), 64'd0);
    end
    check("ovr_full_valid",  64'(initiator_tvalid), 64'd1);
    check("ovr_full_tready", 64'(target_tready),    64'd0);
    rd_idx = 0;
    guard  = 0;
    initiator_tready = 1'b1;
    while (rd_idx < 20 && guard < 80) begin
      target_tvalid = (wr_idx < 20);
      target_tdata  = bd(100 + wr_idx);
      target_tlast  = (wr_idx == 19);
      if (initiator_tvalid) begin
        check("ovr_data", initiator_tdata,       bd(100 + rd_idx));
        check("ovr_last", 64'(initiator_tlast),  64'(rd_idx == 19));
      end
      if (target_tvalid && target_tready) wr_idx++;
      if (initiator_tvalid) rd_idx++;
      tick();
      guard++;
    end
    target_tvalid    = 1'b0;
    target_tlast     = 1'b0;
    initiator_tready = 1'b0;
    check("ovr_all_delivered", 64'(rd_idx),             64'd20);
    check("ovr_forcing_clear", 64'(dut.forcing),        64'd0);
    check("ovr_empty",         64'(initiator_tvalid),   64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
